// File: rtl/l2_word_responder.sv
// Backing-memory stand-in for L2: serves one word-aligned read at a time after a fixed latency,
// with a preload write port for tests and boot images.
module l2_word_responder #(
    parameter int XLEN      = 32,
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            l2_req_valid,
    input  logic [XLEN-1:0] l2_req_address,
    output logic            l2_req_fulfilled,
    output logic [XLEN-1:0] l2_fetched_word,
    input  logic            preload_we,
    input  logic [XLEN-1:0] preload_address,
    input  logic [XLEN-1:0] preload_data,
    output logic            busy,
    output logic            protocol_error,
    output logic [15:0]     resp_count,
    output logic [1:0]      o_dbg_state
);

    localparam int IDX_W     = $clog2(MEM_WORDS);
    localparam int CNT_W     = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam int WAIT_INIT = (LATENCY > 1) ? LATENCY - 2 : 0;

    if (XLEN != 32) begin : g_bad_xlen
        $error("l2_word_responder: only XLEN=32 is supported");
    end
    if ((MEM_WORDS < 2) || ((MEM_WORDS & (MEM_WORDS - 1)) != 0)) begin : g_bad_depth
        $error("l2_word_responder: MEM_WORDS must be a power of two");
    end
    if (LATENCY < 1) begin : g_bad_latency
        $error("l2_word_responder: LATENCY must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_RESPOND = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic [XLEN-1:0]    r_mem [MEM_WORDS];

    logic [IDX_W-1:0]   w_req_idx;
    logic [IDX_W-1:0]   w_pl_idx;
    logic               w_unused;

    // Upper address bits are ignored on purpose: addresses alias modulo MEM_WORDS*4.
    assign w_req_idx = l2_req_address[2 +: IDX_W];
    assign w_pl_idx  = preload_address[2 +: IDX_W];
    assign w_unused  = ^{l2_req_address[XLEN-1:IDX_W+2], l2_req_address[1:0],
                         preload_address[XLEN-1:IDX_W+2], preload_address[1:0]};

    assign busy        = (r_state != S_IDLE);
    assign o_dbg_state = r_state;

    // Backing store is never reset; a write is visible to reads on later edges only.
    always_ff @(posedge clk) begin
        if (preload_we) begin
            r_mem[w_pl_idx] <= preload_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_cnt            <= '0;
            r_idx            <= '0;
            l2_req_fulfilled <= 1'b0;
            l2_fetched_word  <= '0;
            protocol_error   <= 1'b0;
            resp_count       <= '0;
        end else begin
            l2_req_fulfilled <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (l2_req_valid) begin
                        r_idx <= w_req_idx;
                        if (LATENCY == 1) begin
                            r_state          <= S_RESPOND;
                            l2_req_fulfilled <= 1'b1;
                            l2_fetched_word  <= r_mem[w_req_idx];
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= CNT_W'(WAIT_INIT);
                        end
                    end
                end
                S_WAIT: begin
                    if (!l2_req_valid) begin
                        r_state <= S_IDLE;
                    end else begin
                        if (w_req_idx != r_idx) begin
                            protocol_error <= 1'b1;
                        end
                        if (r_cnt == '0) begin
                            r_state          <= S_RESPOND;
                            l2_req_fulfilled <= 1'b1;
                            l2_fetched_word  <= r_mem[r_idx];
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                S_RESPOND: begin
                    r_state    <= S_IDLE;
                    resp_count <= resp_count + 16'd1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l2_word_responder.sv
// Randomized self-checking bench for l2_word_responder: LATENCY=4 main instance plus a
// LATENCY=1 instance sharing the preload bus, checked against a word-array reference model.
module tb_l2_word_responder;

    localparam int LAT   = 4;
    localparam int DEPTH = 1024;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic        req_valid, v1;
    logic [31:0] req_addr, a1;
    logic        fulfilled, f1;
    logic [31:0] fetched, w1;
    logic        pl_we;
    logic [31:0] pl_addr, pl_data_s;
    logic        busy, busy1;
    logic        perr, perr1;
    logic [15:0] resp_count, cnt1;
    logic [1:0]  dbg_state, dbg_state1;

    l2_word_responder #(.XLEN(32), .MEM_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
        .clk(clk), .reset(reset),
        .l2_req_valid(req_valid), .l2_req_address(req_addr),
        .l2_req_fulfilled(fulfilled), .l2_fetched_word(fetched),
        .preload_we(pl_we), .preload_address(pl_addr), .preload_data(pl_data_s),
        .busy(busy), .protocol_error(perr), .resp_count(resp_count),
        .o_dbg_state(dbg_state)
    );

    l2_word_responder #(.XLEN(32), .MEM_WORDS(DEPTH), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .reset(reset),
        .l2_req_valid(v1), .l2_req_address(a1),
        .l2_req_fulfilled(f1), .l2_fetched_word(w1),
        .preload_we(pl_we), .preload_address(pl_addr), .preload_data(pl_data_s),
        .busy(busy1), .protocol_error(perr1), .resp_count(cnt1),
        .o_dbg_state(dbg_state1)
    );

    // ---------------- reference model / scoreboard ----------------
    logic [31:0] mem_m [DEPTH];
    logic [31:0] exp_q [$];
    int          model_cnt  = 0;
    int          model_cnt1 = 0;
    bit          model_perr = 0;
    int          pulse_cnt  = 0;
    bit          chain      = 0;
    int          last_pulse = 0;
    int          n_vec      = 0;
    int          n_err      = 0;

    // Every fulfilled pulse from either instance, used to catch stray pulses.
    always @(negedge clk) begin
        if (fulfilled) pulse_cnt++;
        if (f1) pulse_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_vec++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp_v, cyc);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        if (chain) begin
            req_valid = 1'b0;
            chain     = 1'b0;
        end
        repeat (n) @(negedge clk);
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        if (chain) begin
            req_valid = 1'b0;
            chain     = 1'b0;
        end
        @(negedge clk);
        pl_we = 1'b1; pl_addr = a; pl_data_s = d;
        @(negedge clk);
        pl_we = 1'b0;
        mem_m[widx(a)] = d;
    endtask

    // One request on the LATENCY=4 instance. chg_at/pl_at/abort_at are cycle offsets after
    // acceptance (0 = unused) for an address change, a same-word preload, or dropping valid.
    // keep=1 leaves valid high after the pulse so the next call is issued back-to-back.
    task automatic do_req(input logic [31:0] addr, input bit keep, input int chg_at,
                          input logic [31:0] chg_addr, input int pl_at,
                          input logic [31:0] pl_data, input int abort_at);
        int t0;
        bit got;
        int idx;
        idx = widx(addr);
        if (chain) begin
            req_addr = addr;
            @(negedge clk);
            check("idle_gap_pulse", fulfilled, 0);
        end else begin
            @(negedge clk);
            req_valid = 1'b1;
            req_addr  = addr;
        end
        chain = 1'b0;
        t0 = cyc;
        check("resp_count", resp_count, model_cnt[15:0]);
        check("busy_idle", busy, 0);
        // A preload strictly before the data-load edge is visible; on that edge it is not.
        if (abort_at == 0)
            exp_q.push_back((pl_at > 0 && pl_at < LAT - 1) ? pl_data : mem_m[idx]);
        got = 1'b0;
        for (int n = 1; n <= LAT + 2 && !got; n++) begin
            @(negedge clk);
            if (fulfilled) begin
                if (abort_at > 0) begin
                    check("abort_pulse", 1, 0);
                end else begin
                    got = 1'b1;
                    last_pulse = cyc;
                    model_cnt++;
                    check("latency", cyc - t0, LAT);
                    check("word", fetched, exp_q.pop_front());
                end
            end else if (n < LAT) begin
                check("busy_wait", busy, (abort_at == 0 || n <= abort_at) ? 1 : 0);
            end
            if (pl_at > 0 && n == pl_at + 1) begin
                pl_we = 1'b0;
                mem_m[idx] = pl_data;
            end
            if (pl_at > 0 && n == pl_at) begin
                pl_we = 1'b1; pl_addr = addr; pl_data_s = pl_data;
            end
            if (chg_at > 0 && n == chg_at) begin
                req_addr = chg_addr;
                if (widx(chg_addr) != idx) model_perr = 1'b1;
            end
            if (abort_at > 0 && n == abort_at) req_valid = 1'b0;
        end
        if (got && !keep) req_valid = 1'b0;
        chain = got && keep;
        if (abort_at == 0 && !got) begin
            check("timeout", 0, 1);
            req_valid = 1'b0;
            pl_we     = 1'b0;
            exp_q.delete();
        end
        if (abort_at > 0) check("abort_idle", busy, 0);
        check("protocol_error", perr, model_perr);
    endtask

    task automatic rd(input logic [31:0] addr, input bit keep);
        do_req(addr, keep, 0, 32'h0, 0, 32'h0, 0);
    endtask

    // One request on the LATENCY=1 instance: pulse in the cycle right after acceptance only.
    task automatic rd1(input logic [31:0] a);
        @(negedge clk);
        v1 = 1'b1; a1 = a;
        check("l1_count", cnt1, model_cnt1[15:0]);
        check("l1_busy_idle", busy1, 0);
        @(negedge clk);
        check("l1_pulse", f1, 1);
        check("l1_word", w1, mem_m[widx(a)]);
        v1 = 1'b0;
        model_cnt1++;
        @(negedge clk);
        check("l1_pulse_end", f1, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          op;
        int          prev;
        logic [31:0] a;

        reset = 1'b1;
        req_valid = 1'b0; req_addr = '0;
        v1 = 1'b0; a1 = '0;
        pl_we = 1'b0; pl_addr = '0; pl_data_s = '0;
        repeat (3) @(negedge clk);
        check("rst_fulfilled", fulfilled, 0);
        check("rst_word", fetched, 0);
        check("rst_busy", busy, 0);
        check("rst_perr", perr, 0);
        check("rst_count", resp_count, 0);
        check("rst_l1_count", cnt1, 0);
        reset = 1'b0;

        // basic read
        preload(32'h0000_0100, 32'hCAFE_F00D);
        rd(32'h0000_0100, 0);
        idle(2);
        check("basic_count", resp_count, 1);

        // line refill, highest word first, back-to-back
        for (int k = 0; k < 8; k++) preload(32'h200 + 32'(4 * k), 32'h1111_1111 * 32'(k + 1));
        for (int i = 7; i >= 0; i--) begin
            prev = last_pulse;
            rd(32'h200 + 32'(4 * i), i != 0);
            if (i != 7) check("refill_spacing", last_pulse - prev, LAT + 1);
        end
        idle(2);
        check("refill_count", resp_count, 9);

        // abort then a normal request
        preload(32'h0000_0084, 32'hA5A5_0084);
        do_req(32'h0000_0080, 0, 0, 32'h0, 0, 32'h0, 2);
        rd(32'h0000_0084, 0);

        // randomized mix over words 0..15 with random aliasing upper bits
        for (int k = 0; k < 16; k++) preload(32'(4 * k), $urandom());
        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 9);
            a  = ($urandom() & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
            case (op)
                0, 1:    preload(a, $urandom());
                2:       do_req(a, 0, 0, 32'h0, 0, 32'h0, $urandom_range(1, LAT - 1));
                3:       do_req(a, 0, 0, 32'h0, $urandom_range(1, LAT - 1), $urandom(), 0);
                default: rd(a, 1'($urandom_range(0, 1)));
            endcase
        end
        idle(2);
        check("random_count", resp_count, model_cnt[15:0]);

        // collision on the load edge, re-read, aliasing
        preload(32'h0000_0010, 32'h0BAD_BEEF);
        do_req(32'h0000_0010, 0, 0, 32'h0, LAT - 1, 32'h1234_5678, 0);
        rd(32'h0000_0010, 0);
        preload(32'h0000_0000, 32'h600D_F00D);
        rd(32'h0000_1000, 0);

        // protocol error: address change in WAIT, sticky afterwards
        preload(32'h0000_0040, 32'h4040_4040);
        preload(32'h0000_0044, 32'h4444_4444);
        preload(32'h0000_0048, 32'h4848_4848);
        do_req(32'h0000_0040, 0, 1, 32'h0000_0044, 0, 32'h0, 0);
        rd(32'h0000_0048, 0);

        // LATENCY=1 instance
        for (int it = 0; it < 10; it++)
            rd1(($urandom() & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2));

        idle(2);
        check("pulse_total", pulse_cnt, model_cnt + model_cnt1);

        // reset while in WAIT
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0000_0100;
        repeat (2) @(negedge clk);
        reset = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_cnt = 0; model_cnt1 = 0; model_perr = 1'b0;
        for (int n = 0; n < LAT + 2; n++) begin
            check("rst_mid_no_pulse", fulfilled, 0);
            @(negedge clk);
        end
        check("rst_mid_word", fetched, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_perr", perr, 0);
        check("rst_mid_count", resp_count, 0);
        check("rst_mid_l1_count", cnt1, 0);
        check("rst_mid_l1_word", w1, 0);
        rd(32'h0000_0100, 0);
        idle(2);
        check("post_rst_count", resp_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/l2_word_responder.md
Name: l2_word_responder

Overview:
- Backing-memory responder for the word-serial refill interface that the instruction cache drives toward L2.
- Accepts one word-aligned read request at a time.
- Returns the addressed word after a fixed, parameterised latency, with a single-cycle fulfilled pulse.
- Acts as the simulation and FPGA stand-in for L2 beneath icache/dcache refill controllers, and provides a preload write port for tests and boot images.

Parameters:
- XLEN, 32: data and address width; only 32 supported ($error otherwise).
- MEM_WORDS, 1024: backing store depth in words; power of two ($error otherwise).
- LATENCY, 4: cycles from request acceptance to fulfilled pulse; must be >= 1 ($error otherwise).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- l2_req_valid  input  1  initiator holds high while a word is wanted.
- l2_req_address  input  XLEN  byte address of requested word; bits [1:0] ignored.
- l2_req_fulfilled  output  1  one-cycle pulse; l2_fetched_word is valid this cycle.
- l2_fetched_word  output  XLEN  returned word, registered.
- preload_we  input  1  backing-store write enable.
- preload_address  input  XLEN  byte address for preload; bits [1:0] ignored.
- preload_data  input  XLEN  preload write data.
- busy  output  1  high in WAIT or RESPOND.
- protocol_error  output  1  sticky; set on address change during an outstanding request.
- resp_count  output  16  count of fulfilled responses.

Behaviour:
- Indexing:
  - word index = address[2 +: $clog2(MEM_WORDS)]; upper bits ignored, so addresses alias modulo MEM_WORDS*4.
  - Memory contents are not reset.
- Reset values: FSM = IDLE, l2_req_fulfilled = 0, l2_fetched_word = 0, busy = 0, protocol_error = 0, resp_count = 0, latency counter = 0.
- Reset mid-request: the request is abandoned with no pulse, and FSM returns to IDLE on the next edge.
- FSM states are IDLE, WAIT, RESPOND.
- IDLE:
  - If l2_req_valid = 1 at the edge, capture the word index.
  - If LATENCY = 1, go to RESPOND; else go to WAIT with counter = LATENCY-2.
- WAIT:
  - If l2_req_valid = 0, abort to IDLE with no pulse and no count increment.
  - Else, if counter = 0, go to RESPOND; else decrement the counter.
- RESPOND:
  - l2_req_fulfilled = 1 for exactly this one cycle.
  - Next state is always IDLE; a new request may be accepted on the following edge.
- Latency:
  - Accept at the edge ending cycle t; fulfilled is high in cycle t+LATENCY.
  - Minimum back-to-back spacing is LATENCY+1 cycles per word.
- l2_fetched_word is loaded from memory[captured index] on the edge entering RESPOND, and holds that value afterward until the next response.
- Address stability rules:
  - The captured index is used even if l2_req_address changes after acceptance.
  - A change of word index while in WAIT, with valid still high, sets protocol_error.
  - protocol_error clears only on reset.
- Dropping valid during RESPOND does not suppress the pulse; the response is still counted.
- Preload writes:
  - preload_we writes memory[preload index] on the edge, in any state.
  - Write/read collision: a write on the same edge that loads l2_fetched_word is not visible in that response (old data returned); a write on an earlier edge is visible.
- resp_count increments on every RESPOND cycle and wraps 0xFFFF -> 0x0000.
- busy = (state != IDLE).

Test Plan:
- Basic read, LATENCY=4:
  - Preload word 0x40 = 0xCAFEF00D; then valid=1, addr=0x0000_0100 accepted at cycle 10.
  - Required: fulfilled only in cycle 14, word 0xCAFEF00D, resp_count=1.
- Line refill sequence:
  - Preload 8 words at 0x200..0x21C with 0x11111111..0x88888888; initiator issues 0x21C down to 0x200 back-to-back.
  - Required: 8 pulses spaced 5 cycles apart, correct words in order, resp_count=8.
- Abort:
  - Accept at 0x80, drop valid two cycles later.
  - Required: no pulse, FSM IDLE, resp_count unchanged; a new request to 0x84 then completes normally.
- Protocol error:
  - Accept at 0x40, change address to 0x44 in WAIT with valid held.
  - Required: protocol_error=1 (sticky), data returned is from 0x40.
- Collision and aliasing:
  - Preload write 0x12345678 to the requested word on the edge entering RESPOND.
  - Required: old value returned; a re-read returns 0x12345678.
  - Address 0x0000_1000 with MEM_WORDS=1024 aliases word 0.
- LATENCY=1 plus reset:
  - Accept at cycle t; required: fulfilled at t+1.
  - Assert reset in WAIT with LATENCY=4; required: no pulse, all outputs at reset values, resp_count=0.
